// File: rtl/ssd1289_bus_arbiter_if.sv
// Write-side bus bundle for the SSD1289 arbiter: requester handshakes plus the
// 8080-style panel pins and status flags.
interface ssd1289_bus_arbiter_if;
    logic [16:0] init_din;
    logic        init_valid;
    logic        init_done;
    logic [16:0] cmd_din;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] pix_din;
    logic        pix_valid;
    logic        pix_last;
    logic        pix_ready;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [15:0] lcd_db;
    logic        busy;
    logic        init_overflow;

    modport master (
        output init_din, init_valid, init_done, cmd_din, cmd_valid,
               pix_din, pix_valid, pix_last,
        input  cmd_ready, pix_ready, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db,
               busy, init_overflow
    );

    modport slave (
        input  init_din, init_valid, init_done, cmd_din, cmd_valid,
               pix_din, pix_valid, pix_last,
        output cmd_ready, pix_ready, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db,
               busy, init_overflow
    );
endinterface

// File: rtl/ssd1289_bus_arbiter.sv
// SSD1289 write-bus owner: buffers the init stream, then arbitrates command vs
// pixel words and serialises each onto lcd_db/lcd_rs/lcd_wr_n.
module ssd1289_bus_arbiter #(
    parameter int INIT_FIFO_DEPTH = 64,
    parameter int WR_LOW_CYC      = 2,
    parameter int WR_HIGH_CYC     = 2
) (
    input logic                  sys_clk,
    input logic                  rst_n,
    ssd1289_bus_arbiter_if.slave bus
);
    localparam int AW   = $clog2(INIT_FIFO_DEPTH);
    localparam int MAXC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WR_LOW, S_WR_HIGH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [16:0]   word_q, word_d;
    logic          load;
    logic          wr_n_q;
    logic          lock_q;
    logic          overflow_q;

    logic [16:0]   fifo_mem [INIT_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full, fifo_wr, fifo_rd;
    logic          init_phase, idle, grant_cmd, grant_pix;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_wr    = bus.init_valid && !fifo_full;

    assign idle       = (state_q == S_IDLE);
    assign init_phase = !bus.init_done || !fifo_empty;
    assign fifo_rd    = idle && !fifo_empty;
    assign grant_cmd  = idle && !init_phase && !lock_q && bus.cmd_valid;
    assign grant_pix  = idle && !init_phase && bus.pix_valid && (lock_q || !bus.cmd_valid);

    always_ff @(posedge sys_clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.init_din;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            if (bus.init_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        word_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (fifo_rd) begin
                    word_d = fifo_mem[rd_ptr[AW-1:0]];
                end else if (grant_cmd) begin
                    word_d = bus.cmd_din;
                end else if (grant_pix) begin
                    word_d = {1'b1, bus.pix_din};
                end
                load = fifo_rd || grant_cmd || grant_pix;
                if (load) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_WR_LOW;
                cnt_d   = '0;
            end
            S_WR_LOW: begin
                if (cnt_q == CW'(WR_LOW_CYC - 1)) begin
                    state_d = S_WR_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_HIGH: begin
                if (cnt_q == CW'(WR_HIGH_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe is registered from the next state so it lands exactly with S_WR_LOW.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            wr_n_q  <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= (state_d != S_WR_LOW);
            if (load) word_q <= word_d;
            if (grant_pix) lock_q <= !bus.pix_last;
        end
    end

    assign bus.cmd_ready     = grant_cmd;
    assign bus.pix_ready     = grant_pix;
    assign bus.lcd_rs        = word_q[16];
    assign bus.lcd_db        = word_q[15:0];
    assign bus.lcd_wr_n      = wr_n_q;
    assign bus.lcd_rd_n      = 1'b1;
    assign bus.busy          = !idle;
    assign bus.init_overflow = overflow_q;
endmodule

// File: tb/tb_ssd1289_bus_arbiter.sv
// Directed bench for ssd1289_bus_arbiter: three instances cover default timing,
// a 4-deep init FIFO and WR_LOW_CYC=3/WR_HIGH_CYC=1.
module tb_ssd1289_bus_arbiter;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    ssd1289_bus_arbiter_if if0();
    ssd1289_bus_arbiter_if if1();
    ssd1289_bus_arbiter_if if2();

    ssd1289_bus_arbiter #(.INIT_FIFO_DEPTH(64), .WR_LOW_CYC(2), .WR_HIGH_CYC(2))
        u0 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(if0.slave));
    ssd1289_bus_arbiter #(.INIT_FIFO_DEPTH(4), .WR_LOW_CYC(2), .WR_HIGH_CYC(2))
        u1 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(if1.slave));
    ssd1289_bus_arbiter #(.INIT_FIFO_DEPTH(64), .WR_LOW_CYC(3), .WR_HIGH_CYC(1))
        u2 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(if2.slave));

    int checks = 0;
    int errors = 0;

    // Bus monitor: records each wr_n pulse (word, fall cycle, low length) per DUT.
    logic        wr_s [3];
    logic        busy_s [3];
    logic [16:0] word_s [3];
    assign wr_s[0] = if0.lcd_wr_n;  assign busy_s[0] = if0.busy;  assign word_s[0] = {if0.lcd_rs, if0.lcd_db};
    assign wr_s[1] = if1.lcd_wr_n;  assign busy_s[1] = if1.busy;  assign word_s[1] = {if1.lcd_rs, if1.lcd_db};
    assign wr_s[2] = if2.lcd_wr_n;  assign busy_s[2] = if2.busy;  assign word_s[2] = {if2.lcd_rs, if2.lcd_db};

    int          cyc = 0;
    logic [16:0] cap_w [3][128];
    int          fall_c [3][128];
    int          low_len [3][128];
    int          cap_n [3]    = '{0, 0, 0};
    int          cur_low [3]  = '{0, 0, 0};
    int          stab_err [3] = '{0, 0, 0};
    logic        prev_wr [3]  = '{1'b1, 1'b1, 1'b1};
    logic        prev_busy [3] = '{1'b0, 1'b0, 1'b0};
    logic [16:0] prev_word [3] = '{17'h0, 17'h0, 17'h0};

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        for (int d = 0; d < 3; d++) begin
            if (wr_s[d] === 1'b0 && prev_wr[d] === 1'b1) begin
                if (cap_n[d] < 128) begin
                    cap_w[d][cap_n[d]]  <= word_s[d];
                    fall_c[d][cap_n[d]] <= cyc;
                end
                cap_n[d]   <= cap_n[d] + 1;
                cur_low[d] <= 1;
            end else if (wr_s[d] === 1'b0) begin
                cur_low[d] <= cur_low[d] + 1;
            end
            if (wr_s[d] === 1'b1 && prev_wr[d] === 1'b0 && cap_n[d] > 0 && cap_n[d] <= 128)
                low_len[d][cap_n[d]-1] <= cur_low[d];
            if (prev_busy[d] === 1'b1 && word_s[d] !== prev_word[d])
                stab_err[d] <= stab_err[d] + 1;
            prev_wr[d]   <= wr_s[d];
            prev_busy[d] <= busy_s[d];
            prev_word[d] <= word_s[d];
        end
    end

    // Stimulus tables for the u0 sequencer task.
    logic [16:0] iq [64];
    int          iq_n = 0;
    logic [15:0] pq_d [8];
    logic        pq_l [8];
    int          pq_n = 0;
    logic        cmd_use = 1'b0;
    int          cmd_after = 0;
    logic [16:0] cmd_word = '0;
    int          cmd_acc_pix;
    int          early_err;

    function automatic logic [16:0] init_word(input int i);
        logic [15:0] v;
        v = 16'h0100 + 16'(i);
        if (i == 0)  return 17'h00007;
        if (i == 1)  return 17'h10021;
        if (i == 39) return 17'h10808;
        return {i[0], v};
    endfunction

    task automatic clear_inputs();
        if0.init_din = '0; if0.init_valid = 0; if0.init_done = 0; if0.cmd_din = '0;
        if0.cmd_valid = 0; if0.pix_din = '0; if0.pix_valid = 0; if0.pix_last = 0;
        if1.init_din = '0; if1.init_valid = 0; if1.init_done = 0; if1.cmd_din = '0;
        if1.cmd_valid = 0; if1.pix_din = '0; if1.pix_valid = 0; if1.pix_last = 0;
        if2.init_din = '0; if2.init_valid = 0; if2.init_done = 0; if2.cmd_din = '0;
        if2.cmd_valid = 0; if2.pix_din = '0; if2.pix_valid = 0; if2.pix_last = 0;
    endtask

    // Plays iq/pq/cmd into u0 with ready handshakes until n_words pulses are seen.
    task automatic run_u0(input int base, input int n_words, input int bound);
        int   k, ii, pi, pix_acc;
        logic cmd_fire, pix_fire, cmd_done;
        ii = 0; pi = 0; pix_acc = 0; cmd_fire = 0; pix_fire = 0;
        cmd_done = !cmd_use; cmd_acc_pix = -1; early_err = 0;
        for (k = 0; k < bound; k++) begin
            @(negedge sys_clk);
            if (cmd_fire) begin
                if0.cmd_valid = 0; cmd_fire = 0; cmd_done = 1; cmd_acc_pix = pix_acc;
            end
            if (pix_fire) begin pix_fire = 0; pi++; pix_acc++; end
            if (ii < iq_n) begin
                if0.init_valid = 1; if0.init_din = iq[ii]; ii++;
            end else begin
                if0.init_valid = 0; if0.init_done = 1;
            end
            if (!cmd_done && pix_acc >= cmd_after) begin if0.cmd_valid = 1; if0.cmd_din = cmd_word; end
            if (pi < pq_n) begin
                if0.pix_valid = 1; if0.pix_din = pq_d[pi]; if0.pix_last = pq_l[pi];
            end else begin
                if0.pix_valid = 0; if0.pix_last = 0;
            end
            #1;
            if (if0.cmd_ready === 1'b1 && (cap_n[0] - base) < iq_n) early_err++;
            if (if0.cmd_ready === 1'b1 && if0.cmd_valid) cmd_fire = 1;
            if (if0.pix_ready === 1'b1 && if0.pix_valid) pix_fire = 1;
            if (cap_n[0] - base >= n_words && if0.busy === 1'b0 && cmd_done && pi >= pq_n
                && !cmd_fire && !pix_fire) break;
        end
        checks++;
        if (k >= bound) begin errors++; $display("FAIL u0_timeout got %0d want <%0d", k, bound); end
    endtask

    task automatic wait_caps(input int d, input int base, input int n, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge sys_clk);
            #1;
            if (cap_n[d] - base >= n && busy_s[d] === 1'b0) break;
        end
        checks++;
        if (k >= bound) begin errors++; $display("FAIL wait_timeout dut %0d got %0d want %0d", d, cap_n[d] - base, n); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        checks++; if (if0.lcd_wr_n !== 1'b1) begin errors++; $display("FAIL rst_wr_n got %b want 1", if0.lcd_wr_n); end
        checks++; if (if0.lcd_rd_n !== 1'b1) begin errors++; $display("FAIL rst_rd_n got %b want 1", if0.lcd_rd_n); end
        checks++; if (if0.lcd_db !== 16'h0) begin errors++; $display("FAIL rst_db got %h want 0000", if0.lcd_db); end
        checks++; if (if0.lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs got %b want 0", if0.lcd_rs); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", if0.busy); end
        checks++; if ({if0.cmd_ready, if0.pix_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", {if0.cmd_ready, if0.pix_ready}); end
        checks++; if (if1.init_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", if1.init_overflow); end
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_init_burst();
        int base;
        for (int i = 0; i < 40; i++) iq[i] = init_word(i);
        iq_n = 40; pq_n = 0; cmd_use = 1; cmd_after = 0; cmd_word = 17'h00033;
        base = cap_n[0];
        run_u0(base, 41, 400);
        checks++; if (cap_n[0] - base !== 41) begin errors++; $display("FAIL init_count got %0d want 41", cap_n[0] - base); end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (cap_w[0][base+i] !== init_word(i)) begin errors++; $display("FAIL init_word[%0d] got %h want %h", i, cap_w[0][base+i], init_word(i)); end
            checks++;
            if (low_len[0][base+i] !== 2) begin errors++; $display("FAIL init_low[%0d] got %0d want 2", i, low_len[0][base+i]); end
        end
        for (int i = 0; i < 39; i++) begin
            checks++;
            if (fall_c[0][base+i+1] - fall_c[0][base+i] !== 6) begin
                errors++; $display("FAIL init_period[%0d] got %0d want 6", i, fall_c[0][base+i+1] - fall_c[0][base+i]);
            end
        end
        checks++; if (cap_w[0][base+40] !== 17'h00033) begin errors++; $display("FAIL init_cmd_after got %h want 00033", cap_w[0][base+40]); end
        checks++; if (early_err !== 0) begin errors++; $display("FAIL init_cmd_ready_early got %0d want 0", early_err); end
        checks++; if (if0.init_overflow !== 1'b0) begin errors++; $display("FAIL init_no_ovf got %b want 0", if0.init_overflow); end
        iq_n = 0;
    endtask

    task automatic test_priority();
        int base;
        pq_d[0] = 16'hF800; pq_l[0] = 1'b1; pq_n = 1;
        cmd_use = 1; cmd_after = 0; cmd_word = 17'h00022;
        base = cap_n[0];
        run_u0(base, 2, 60);
        checks++; if (cap_w[0][base] !== 17'h00022) begin errors++; $display("FAIL prio_first got %h want 00022", cap_w[0][base]); end
        checks++; if (cap_w[0][base+1] !== 17'h1F800) begin errors++; $display("FAIL prio_second got %h want 1f800", cap_w[0][base+1]); end
        checks++; if (cmd_acc_pix !== 0) begin errors++; $display("FAIL prio_cmd_order got %0d want 0", cmd_acc_pix); end
    endtask

    task automatic test_burst_lock();
        int base;
        pq_d[0] = 16'h0001; pq_l[0] = 1'b0;
        pq_d[1] = 16'h0002; pq_l[1] = 1'b0;
        pq_d[2] = 16'h0003; pq_l[2] = 1'b1;
        pq_n = 3; cmd_use = 1; cmd_after = 1; cmd_word = 17'h00044;
        base = cap_n[0];
        run_u0(base, 4, 100);
        checks++; if (cmd_acc_pix !== 3) begin errors++; $display("FAIL lock_cmd_wait got %0d want 3", cmd_acc_pix); end
        checks++; if (cap_w[0][base] !== 17'h10001) begin errors++; $display("FAIL lock_w0 got %h want 10001", cap_w[0][base]); end
        checks++; if (cap_w[0][base+1] !== 17'h10002) begin errors++; $display("FAIL lock_w1 got %h want 10002", cap_w[0][base+1]); end
        checks++; if (cap_w[0][base+2] !== 17'h10003) begin errors++; $display("FAIL lock_w2 got %h want 10003", cap_w[0][base+2]); end
        checks++; if (cap_w[0][base+3] !== 17'h00044) begin errors++; $display("FAIL lock_w3 got %h want 00044", cap_w[0][base+3]); end
        checks++; if (fall_c[0][base+2] - fall_c[0][base+1] !== 6) begin errors++; $display("FAIL lock_period got %0d want 6", fall_c[0][base+2] - fall_c[0][base+1]); end
        checks++; if (stab_err[0] !== 0) begin errors++; $display("FAIL u0_bus_stable got %0d want 0", stab_err[0]); end
        pq_n = 0; cmd_use = 0;
    endtask

    task automatic test_overflow();
        int          base;
        logic [16:0] w [8];
        logic [15:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 16'hA000 + 16'(k);
            w[k] = {k[0], v};
        end
        base = cap_n[1];
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            if (k == 5) begin
                checks++; if (if1.init_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", if1.init_overflow); end
            end
            if1.init_valid = 1; if1.init_din = w[k];
        end
        @(negedge sys_clk);
        if1.init_valid = 0; if1.init_done = 1;
        wait_caps(1, base, 5, 80);
        repeat (12) @(negedge sys_clk);
        checks++; if (if1.init_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", if1.init_overflow); end
        checks++; if (cap_n[1] - base !== 5) begin errors++; $display("FAIL ovf_count got %0d want 5", cap_n[1] - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_w[1][base+i] !== w[i]) begin errors++; $display("FAIL ovf_word[%0d] got %h want %h", i, cap_w[1][base+i], w[i]); end
        end
    endtask

    task automatic test_timing();
        int          base;
        logic [16:0] w [3];
        w[0] = 17'h11234; w[1] = 17'h05678; w[2] = 17'h19ABC;
        base = cap_n[2];
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            if2.init_valid = 1; if2.init_din = w[k];
        end
        @(negedge sys_clk);
        if2.init_valid = 0; if2.init_done = 1;
        wait_caps(2, base, 3, 60);
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_w[2][base+i] !== w[i]) begin errors++; $display("FAIL tim_word[%0d] got %h want %h", i, cap_w[2][base+i], w[i]); end
            checks++; if (low_len[2][base+i] !== 3) begin errors++; $display("FAIL tim_low[%0d] got %0d want 3", i, low_len[2][base+i]); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (fall_c[2][base+i+1] - fall_c[2][base+i] !== 6) begin
                errors++; $display("FAIL tim_period[%0d] got %0d want 6", i, fall_c[2][base+i+1] - fall_c[2][base+i]);
            end
        end
        checks++; if (stab_err[2] !== 0) begin errors++; $display("FAIL tim_bus_stable got %0d want 0", stab_err[2]); end
    endtask

    task automatic test_reset_mid_write();
        int base, k;
        base = cap_n[0];
        @(negedge sys_clk);
        if0.cmd_valid = 1; if0.cmd_din = 17'h00055;
        #1;
        checks++; if (if0.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %b want 1", if0.cmd_ready); end
        @(negedge sys_clk);
        if0.cmd_valid = 0;
        for (k = 0; k < 10; k++) begin
            if (if0.lcd_wr_n === 1'b0) break;
            @(negedge sys_clk);
        end
        checks++; if (if0.lcd_wr_n !== 1'b0) begin errors++; $display("FAIL mid_wr_low got %b want 0", if0.lcd_wr_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (if0.lcd_wr_n !== 1'b1) begin errors++; $display("FAIL mid_rst_wr_n got %b want 1", if0.lcd_wr_n); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", if0.busy); end
        checks++; if (if0.lcd_db !== 16'h0) begin errors++; $display("FAIL mid_rst_db got %h want 0000", if0.lcd_db); end
        checks++; if (if1.init_overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b want 0", if1.init_overflow); end
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (12) @(negedge sys_clk);
        checks++; if (cap_n[0] - base !== 1) begin errors++; $display("FAIL mid_abandon got %0d want 1", cap_n[0] - base); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_init_burst();
        test_priority();
        test_burst_lock();
        test_overflow();
        test_timing();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
